four_bit_cla_divider: RTL and testbench



---
 rtl/four_bit_cla_divider_if.sv | 15 +
 rtl/four_bit_cla_divider.sv | 101 ++++++++++
 tb/tb_four_bit_cla_divider.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/four_bit_cla_divider_if.sv
// four_bit_cla_divider_if: start/busy/done handshake and operand/result bus of the divider.
interface four_bit_cla_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    modport master (output start, a, b, input busy, done, quotient, remainder, div_zero);
    modport slave (input start, a, b, output busy, done, quotient, remainder, div_zero);
endinterface

// File: rtl/four_bit_cla_divider.sv
// four_bit_cla_divider: sequential restoring divider, one MSB-first step per cycle.
// Each step subtracts through a carry-lookahead a + ~b + 1; b == 0 completes immediately.
module four_bit_cla_divider #(
    parameter int WIDTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    four_bit_cla_divider_if.slave s
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem, r_q, r_b, r_quot, r_rem_out;
    logic             r_dz;
    logic             w_accept, w_borrow, w_cout;
    logic [WIDTH:0]   w_x, w_y, w_g, w_p;
    logic [WIDTH-1:0] w_c, w_diff, w_rem_next, w_q_next;

    // carry into bit n as a flat sum of generate terms with carry-in 1
    function automatic logic carry(input logic [WIDTH:0] g, input logic [WIDTH:0] p, input int n);
        logic acc, t;
        acc = 1'b0;
        t = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            acc = acc | (t & g[i]);
            t = t & p[i];
        end
        return acc | t;
    endfunction

    assign w_x = {r_rem, r_q[WIDTH-1]};
    assign w_y = ~{1'b0, r_b};
    assign w_g = w_x & w_y;
    assign w_p = w_x ^ w_y;

    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_c
        assign w_c[i] = carry(w_g, w_p, i);
    end

    assign w_cout = carry(w_g, w_p, WIDTH + 1);
    assign w_borrow = ~w_cout;
    assign w_diff = w_p[WIDTH-1:0] ^ w_c;
    assign w_rem_next = w_borrow ? w_x[WIDTH-1:0] : w_diff;
    assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};
    assign w_accept = s.start && (r_state != RUN);

    always_comb begin
        w_next = r_state;
        if (w_accept)
            w_next = (s.b == '0) ? DONE : RUN;
        else if (r_state == RUN)
            w_next = (r_cnt == '0) ? DONE : RUN;
        else if (r_state == DONE)
            w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_b       <= '0;
            r_quot    <= '0;
            r_rem_out <= '0;
            r_dz      <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= CW'(WIDTH - 1);
            r_rem <= '0;
            r_q   <= s.a;
            r_b   <= s.b;
            r_dz  <= (s.b == '0);
            if (s.b == '0) begin
                r_quot    <= '1;
                r_rem_out <= s.a;
            end
        end else if (r_state == RUN) begin
            r_rem <= w_rem_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_quot    <= w_q_next;
                r_rem_out <= w_rem_next;
            end
        end
    end

    assign s.busy      = (r_state == RUN);
    assign s.done      = (r_state == DONE);
    assign s.quotient  = r_quot;
    assign s.remainder = r_rem_out;
    assign s.div_zero  = r_dz;
endmodule

// File: tb/tb_four_bit_cla_divider.sv
// tb_four_bit_cla_divider: directed vector table, handshake corner sequences, exhaustive sweep.
module tb_four_bit_cla_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    four_bit_cla_divider_if #(.WIDTH(4)) bus ();
    four_bit_cla_divider #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .s(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a, b, q, r;
        logic       dz;
        int         lat;
    } vec_t;
    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        tick();
        bus.start = 1'b0;
        bus.a = 4'($urandom);
        bus.b = 4'($urandom);
    endtask

    task automatic wait_done(output int lat, output int nb);
        lat = 1;
        nb = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) nb++;
            tick();
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int q, input int r, input int dz,
                                input int lat_exp, input int lat, input int nb);
        check({tag, "_latency"}, lat, lat_exp);
        check({tag, "_busy_cycles"}, nb, lat_exp - 1);
        check({tag, "_busy_in_done"}, int'(bus.busy), 0);
        check({tag, "_quotient"}, int'(bus.quotient), q);
        check({tag, "_remainder"}, int'(bus.remainder), r);
        check({tag, "_div_zero"}, int'(bus.div_zero), dz);
    endtask

    initial begin
        int lat, nb, dones;
        vecs[0] = '{a: 13, b: 3,  q: 4,  r: 1, dz: 0, lat: 5};
        vecs[1] = '{a: 15, b: 1,  q: 15, r: 0, dz: 0, lat: 5};
        vecs[2] = '{a: 2,  b: 9,  q: 0,  r: 2, dz: 0, lat: 5};
        vecs[3] = '{a: 0,  b: 5,  q: 0,  r: 0, dz: 0, lat: 5};
        vecs[4] = '{a: 15, b: 15, q: 1,  r: 0, dz: 0, lat: 5};
        vecs[5] = '{a: 7,  b: 0,  q: 15, r: 7, dz: 1, lat: 1};
        vecs[6] = '{a: 9,  b: 4,  q: 2,  r: 1, dz: 0, lat: 5};
        vecs[7] = '{a: 8,  b: 8,  q: 1,  r: 0, dz: 0, lat: 5};
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        rst = 1'b1;
        tick();
        tick();
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_quotient", int'(bus.quotient), 0);
        check("reset_remainder", int'(bus.remainder), 0);
        check("reset_div_zero", int'(bus.div_zero), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].a, vecs[i].b);
            wait_done(lat, nb);
            check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat, lat, nb);
            tick();
            check($sformatf("vec%0d_done_one_cycle", i), int'(bus.done), 0);
        end

        // start during RUN must be ignored
        issue(13, 3);
        for (int k = 0; k < 2; k++) begin
            bus.start = 1'b1;
            bus.a = 6;
            bus.b = 2;
            tick();
        end
        bus.start = 1'b0;
        lat = 3;
        nb = 2;
        while (!bus.done && lat < 20) begin
            if (bus.busy) nb++;
            tick();
            lat++;
        end
        check_result("ignore", 4, 1, 0, 5, lat, nb);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.done) dones++;
        end
        check("ignore_no_second_done", dones, 0);

        // reset on the second RUN edge discards the operation
        issue(14, 3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_quotient", int'(bus.quotient), 0);
        check("midrst_remainder", int'(bus.remainder), 0);
        check("midrst_div_zero", int'(bus.div_zero), 0);
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.done || bus.busy) dones++;
        end
        check("midrst_stays_idle", dones, 0);
        issue(14, 3);
        wait_done(lat, nb);
        check_result("after_rst", 4, 2, 0, 5, lat, nb);
        tick();

        // back-to-back: new start accepted in the done cycle
        issue(13, 3);
        wait_done(lat, nb);
        check_result("b2b_first", 4, 1, 0, 5, lat, nb);
        bus.start = 1'b1;
        bus.a = 9;
        bus.b = 2;
        tick();
        bus.start = 1'b0;
        check("b2b_done_drops", int'(bus.done), 0);
        check("b2b_busy", int'(bus.busy), 1);
        wait_done(lat, nb);
        check_result("b2b_second", 4, 1, 0, 5, lat, nb);
        tick();

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(4'(a), 4'(b));
                wait_done(lat, nb);
                if (b == 0)
                    check_result($sformatf("sweep_%0d_%0d", a, b), 15, a, 1, 1, lat, nb);
                else
                    check_result($sformatf("sweep_%0d_%0d", a, b), a / b, a % b, 0, 5, lat, nb);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
